// File: rtl/goertzel_pkg.sv
// Shared constants for the Goertzel bin scheduler: default widths, phase step
// helper and FSM state encoding.
package goertzel_pkg;

  localparam int unsigned SW_DEF     = 12;
  localparam int unsigned N_DEF      = 60;
  localparam int unsigned KW_DEF     = $clog2(N_DEF);
  localparam int unsigned NB_DEF     = 4;
  localparam int unsigned CW_DEF     = 16;
  localparam int unsigned OW_DEF     = 16;
  localparam int unsigned PW_DEF     = 16;
  localparam int unsigned TMO_CYCLES = 1024;
  localparam int unsigned TMO_W      = $clog2(TMO_CYCLES);

  // round(2^pw / n) using integer arithmetic
  function automatic int unsigned phase_step(input int unsigned pw, input int unsigned n);
    longint unsigned full;
    full = 64'd1 << pw;
    return 32'((full + 64'(n / 2)) / 64'(n));
  endfunction

  localparam int unsigned PHASE_STEP = phase_step(PW_DEF, N_DEF);

  localparam int unsigned STW = 3;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COEF_REQ  = 3'd1;
  localparam logic [2:0] ST_COEF_WAIT = 3'd2;
  localparam logic [2:0] ST_CLEAR     = 3'd3;
  localparam logic [2:0] ST_ACCUM     = 3'd4;
  localparam logic [2:0] ST_RES_WAIT  = 3'd5;
  localparam logic [2:0] ST_OUTPUT    = 3'd6;

endpackage

// File: rtl/goertzel_sched_bin_table.sv
// Bin-index register file: NB entries of KW bits, one synchronous write port,
// one combinational read port. Reset loads entry i with k = i.
module goertzel_bin_table
  import goertzel_pkg::*;
#(
  parameter int unsigned NB = NB_DEF,
  parameter int unsigned KW = KW_DEF,
  localparam int unsigned AW = $clog2(NB)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr,
  input  logic [AW-1:0] i_waddr,
  input  logic [KW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [KW-1:0] o_rdata
);

  logic [KW-1:0] r_mem [NB];

  // Table storage: default identity mapping on reset, single write port
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(NB); i++) begin
        r_mem[i] <= KW'(i);
      end
    end else if (i_wr) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/goertzel_sched.sv
// Goertzel bin scheduler: sweeps NB table bins, requesting a coefficient per
// bin, streaming N samples into the external core and returning its power.
// Optional macro GOERTZEL_SCHED_TIMEOUT_EN bounds the coefficient and result
// waits to 1024 cycles and adds the o_timeout pulse output.
module goertzel_sched
  import goertzel_pkg::*;
#(
  parameter int unsigned SW = SW_DEF,
  parameter int unsigned N  = N_DEF,
  parameter int unsigned KW = $clog2(N),
  parameter int unsigned NB = NB_DEF,
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned OW = OW_DEF,
  parameter int unsigned PW = PW_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_bin_wr,
  input  logic [$clog2(NB)-1:0]  i_bin_addr,
  input  logic [KW-1:0]          i_bin_k,
  input  logic                   i_sample_valid,
  input  logic signed [SW-1:0]   i_sample,
  output logic                   o_phase_req,
  output logic [PW-1:0]          o_phase,
  input  logic                   i_coef_valid,
  input  logic [CW-1:0]          i_coef,
  output logic                   o_core_clr,
  output logic [CW-1:0]          o_core_coef,
  output logic                   o_core_en,
  output logic signed [SW-1:0]   o_core_sample,
  output logic                   o_core_last,
  input  logic                   i_core_valid,
  input  logic [OW-1:0]          i_core_power,
  output logic                   o_res_valid,
  output logic [$clog2(NB)-1:0]  o_res_bin,
  output logic [OW-1:0]          o_res_power,
  input  logic                   i_res_ready,
  output logic                   o_busy,
  output logic                   o_overrun
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
  ,
  output logic                   o_timeout
`endif
);

  localparam int unsigned AW     = $clog2(NB);
  localparam int unsigned CNTW   = $clog2(N);
  localparam int unsigned STEP_L = phase_step(PW, N);

  logic [STW-1:0]         r_state, w_state_nxt;
  logic [AW-1:0]          r_slot, w_slot_nxt;
  logic [CNTW-1:0]        r_cnt, w_cnt_nxt;
  logic                   r_phase_req, w_phase_req_nxt;
  logic [PW-1:0]          r_phase, w_phase_nxt;
  logic                   r_core_clr, w_core_clr_nxt;
  logic [CW-1:0]          r_core_coef, w_core_coef_nxt;
  logic                   r_core_en, w_core_en_nxt;
  logic signed [SW-1:0]   r_core_sample, w_core_sample_nxt;
  logic                   r_core_last, w_core_last_nxt;
  logic                   r_res_valid, w_res_valid_nxt;
  logic [AW-1:0]          r_res_bin, w_res_bin_nxt;
  logic [OW-1:0]          r_res_power, w_res_power_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_overrun, w_overrun_nxt;
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
  logic [TMO_W-1:0]       r_tmo_cnt, w_tmo_cnt_nxt;
  logic                   r_timeout, w_timeout_nxt;
`endif

  logic [KW-1:0]          w_bin_k;
  logic [31:0]            w_phase_prod;
  logic [PW-1:0]          w_phase;

  goertzel_bin_table #(
    .NB (NB),
    .KW (KW)
  ) u_bin_table (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wr    (i_bin_wr),
    .i_waddr (i_bin_addr),
    .i_wdata (i_bin_k),
    .i_raddr (r_slot),
    .o_rdata (w_bin_k)
  );

  assign w_phase_prod = 32'(w_bin_k) * STEP_L;
  assign w_phase      = PW'(w_phase_prod);

  // Next-state and next-output logic for the sweep sequencer
  always_comb begin
    w_state_nxt       = r_state;
    w_slot_nxt        = r_slot;
    w_cnt_nxt         = r_cnt;
    w_phase_req_nxt   = 1'b0;
    w_phase_nxt       = r_phase;
    w_core_clr_nxt    = 1'b0;
    w_core_coef_nxt   = r_core_coef;
    w_core_en_nxt     = 1'b0;
    w_core_sample_nxt = r_core_sample;
    w_core_last_nxt   = 1'b0;
    w_res_valid_nxt   = r_res_valid;
    w_res_bin_nxt     = r_res_bin;
    w_res_power_nxt   = r_res_power;
    w_overrun_nxt     = r_overrun;
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
    w_tmo_cnt_nxt     = r_tmo_cnt;
    w_timeout_nxt     = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt   = ST_COEF_REQ;
          w_slot_nxt    = '0;
          w_overrun_nxt = 1'b0;
        end
      end
      ST_COEF_REQ: begin
        w_phase_req_nxt = 1'b1;
        w_phase_nxt     = w_phase;
        w_state_nxt     = ST_COEF_WAIT;
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
        w_tmo_cnt_nxt   = '0;
`endif
      end
      ST_COEF_WAIT: begin
        if (i_coef_valid) begin
          w_core_coef_nxt = i_coef;
          w_state_nxt     = ST_CLEAR;
        end
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
        else if (r_tmo_cnt == TMO_W'(TMO_CYCLES - 1)) begin
          w_state_nxt   = ST_IDLE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
        end
`endif
      end
      ST_CLEAR: begin
        w_core_clr_nxt = 1'b1;
        w_cnt_nxt      = '0;
        w_state_nxt    = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (i_sample_valid) begin
          w_core_en_nxt     = 1'b1;
          w_core_sample_nxt = i_sample;
          if (r_cnt == CNTW'(N - 1)) begin
            w_core_last_nxt = 1'b1;
            w_state_nxt     = ST_RES_WAIT;
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
            w_tmo_cnt_nxt   = '0;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CNTW'(1);
          end
        end
      end
      ST_RES_WAIT: begin
        if (i_core_valid) begin
          w_res_power_nxt = i_core_power;
          w_res_bin_nxt   = r_slot;
          w_res_valid_nxt = 1'b1;
          w_state_nxt     = ST_OUTPUT;
        end
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
        else if (r_tmo_cnt == TMO_W'(TMO_CYCLES - 1)) begin
          w_state_nxt   = ST_IDLE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
        end
`endif
      end
      ST_OUTPUT: begin
        if (i_res_ready) begin
          w_res_valid_nxt = 1'b0;
          w_slot_nxt      = r_slot + AW'(1);
          w_state_nxt     = (r_slot == AW'(NB - 1)) ? ST_IDLE : ST_COEF_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Samples arriving while busy but not accumulating are lost
    if (i_sample_valid && (r_state != ST_IDLE) && (r_state != ST_ACCUM)) begin
      w_overrun_nxt = 1'b1;
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_slot        <= '0;
      r_cnt         <= '0;
      r_phase_req   <= 1'b0;
      r_phase       <= '0;
      r_core_clr    <= 1'b0;
      r_core_coef   <= '0;
      r_core_en     <= 1'b0;
      r_core_sample <= '0;
      r_core_last   <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_bin     <= '0;
      r_res_power   <= '0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
      r_tmo_cnt     <= '0;
      r_timeout     <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_slot        <= w_slot_nxt;
      r_cnt         <= w_cnt_nxt;
      r_phase_req   <= w_phase_req_nxt;
      r_phase       <= w_phase_nxt;
      r_core_clr    <= w_core_clr_nxt;
      r_core_coef   <= w_core_coef_nxt;
      r_core_en     <= w_core_en_nxt;
      r_core_sample <= w_core_sample_nxt;
      r_core_last   <= w_core_last_nxt;
      r_res_valid   <= w_res_valid_nxt;
      r_res_bin     <= w_res_bin_nxt;
      r_res_power   <= w_res_power_nxt;
      r_busy        <= w_busy_nxt;
      r_overrun     <= w_overrun_nxt;
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
      r_tmo_cnt     <= w_tmo_cnt_nxt;
      r_timeout     <= w_timeout_nxt;
`endif
    end
  end

  assign o_phase_req   = r_phase_req;
  assign o_phase       = r_phase;
  assign o_core_clr    = r_core_clr;
  assign o_core_coef   = r_core_coef;
  assign o_core_en     = r_core_en;
  assign o_core_sample = r_core_sample;
  assign o_core_last   = r_core_last;
  assign o_res_valid   = r_res_valid;
  assign o_res_bin     = r_res_bin;
  assign o_res_power   = r_res_power;
  assign o_busy        = r_busy;
  assign o_overrun     = r_overrun;
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
  assign o_timeout     = r_timeout;
`endif

endmodule
